// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared constants and loader state encoding for the SAP-1 program loader
package sap_pkg;

    localparam int SAP_ADDR_W = 4;
    localparam int SAP_DEPTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } ld_state_e;

endpackage

// File: rtl/sap_csum_acc.sv
// rtl/sap_csum_acc.sv - 8-bit running-sum register with load, accumulate, clear and zero-check
module sap_csum_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       ld_i,
    input  logic       acc_i,
    input  logic [7:0] din_i,
    output logic       zero_o
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    // Next sum: clear wins, then load (LEN byte seeds the sum), then accumulate
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = 8'h00;
        end else if (ld_i) begin
            sum_d = din_i;
        end else if (acc_i) begin
            sum_d = sum_q + din_i;
        end
    end

    // Running-sum register, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    // A frame checks out when the checksum byte brings the total to zero
    assign zero_o = ((sum_q + din_i) == 8'h00);

endmodule

// File: rtl/sap_prog_loader.sv
// rtl/sap_prog_loader.sv - streams a LEN-prefixed program into SAP-1 RAM and holds the CPU until loaded; option macro SAP_LOADER_CHECKSUM_EN
module sap_prog_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DEPTH  = SAP_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    ld_state_e         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W:0]   len_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;

    logic xfer;
    logic len_ok;
    logic last_byte;

    // Ready depends only on state (and reset), never on in_valid
    assign in_ready  = rst && ((state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CSUM));
    assign xfer      = in_valid && in_ready;
    assign len_ok    = (in_data != 8'h00) && (in_data <= 8'(DEPTH));
    assign last_byte = ({1'b0, cnt_q} == (len_q - (ADDR_W+1)'(1)));

`ifdef SAP_LOADER_CHECKSUM_EN
    logic sum_clr;
    logic sum_ld;
    logic sum_acc;
    logic sum_zero;

    // Sum control: seed with LEN, add each data byte, drop on re-arm
    always_comb begin
        sum_clr = ((state_q == ST_DONE) || (state_q == ST_ERR)) && start;
        sum_ld  = (state_q == ST_IDLE) && xfer;
        sum_acc = (state_q == ST_LOAD) && xfer;
    end

    sap_csum_acc u_csum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (sum_clr),
        .ld_i   (sum_ld),
        .acc_i  (sum_acc),
        .din_i  (in_data),
        .zero_o (sum_zero)
    );
`endif

    // Loader FSM with registered RAM strobe and status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        len_q <= in_data[ADDR_W:0];
                        cnt_q <= '0;
                        if (len_ok) begin
                            state_q <= ST_LOAD;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q;
                        mem_wdata_q <= in_data;
                        // cnt stops at len-1 so the address never wraps
                        if (last_byte) begin
`ifdef SAP_LOADER_CHECKSUM_EN
                            state_q    <= ST_CSUM;
`else
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
`ifdef SAP_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        if (sum_zero) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_IDLE;
                        done_q     <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        cnt_q      <= '0;
                        len_q      <= '0;
                    end
                end
                ST_ERR: begin
                    if (start) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        len_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sap_prog_loader.sv
// tb/tb_sap_prog_loader.sv - scoreboard bench for sap_prog_loader, follows SAP_LOADER_CHECKSUM_EN
module tb_sap_prog_loader;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       start = 1'b0;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    wr_t exp_q[$];

    sap_prog_loader #(.ADDR_W(4), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write, in the right cycle
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (exp_q.size() == 0) begin
                chk("extra_mem_we", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(w.addr));
                chk("wr_data", 32'(mem_wdata), 32'(w.data));
                chk("wr_cycle", 32'(cyc), 32'(w.cyc));
            end
        end
    end

    function automatic bq_t framed(input bq_t body);
        bq_t f;
        logic [7:0] s;
        f = body;
        s = 8'h00;
        foreach (body[i]) s = s + body[i];
`ifdef SAP_LOADER_CHECKSUM_EN
        f.push_back(8'h00 - s);
`endif
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit is_data, input int addr);
        int waited;
        wr_t w;
        waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
            if (is_data) begin
                w.addr = addr[3:0];
                w.data = b;
                w.cyc  = cyc;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic send_frame(input bq_t fr, input int ndata, input bit gaps);
        for (int i = 0; i < fr.size(); i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            send_byte(fr[i], (i >= 1) && (i <= ndata), i - 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        @(negedge clk); #1;
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic expect_err(input string tag);
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        bq_t fr;

        // 1: reset held three cycles
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_rdy", 32'(in_ready), 32'd1);

        // 2: good frame, back-to-back
        fr = framed('{8'h03, 8'h11, 8'h22, 8'h33});
        send_frame(fr, 3, 1'b0);
        expect_done("good");
        drain("good_wq");
        repeat (3) begin @(posedge clk); #1; end
        chk("done_level", 32'(done), 32'd1);
        pulse_start();
        chk("rearm_done", 32'(done), 32'd0);
        chk("rearm_hold", 32'(cpu_hold), 32'd1);
        chk("rearm_rdy", 32'(in_ready), 32'd1);

        // 3: bad checksum (only meaningful with the checksum byte present)
`ifdef SAP_LOADER_CHECKSUM_EN
        send_frame('{8'h02, 8'hAA, 8'hBB, 8'h00}, 2, 1'b0);
        expect_err("badcs");
        drain("badcs_wq");
        pulse_start();
        chk("badcs_clr", 32'(err), 32'd0);
        chk("badcs_rdy", 32'(in_ready), 32'd1);
`else
        send_frame('{8'h01, 8'h5A}, 1, 1'b0);
        expect_done("one");
        drain("one_wq");
        pulse_start();
        chk("one_clr", 32'(done), 32'd0);
`endif

        // 4: bad lengths, zero and DEPTH+1
        send_frame('{8'h00}, 0, 1'b0);
        expect_err("len0");
        pulse_start();
        chk("len0_clr", 32'(err), 32'd0);
        send_frame('{8'h11}, 0, 1'b0);
        expect_err("len17");
        drain("len_wq");
        pulse_start();
        chk("len17_clr", 32'(err), 32'd0);

        // 5: full depth with random valid gaps
        fr = '{8'h10};
        for (int i = 0; i < 16; i++) fr.push_back(8'(i));
        fr = framed(fr);
        send_frame(fr, 16, 1'b1);
        expect_done("full");
        drain("full_wq");
        pulse_start();

        // 6: start ignored mid-LOAD, then reset mid-frame and reload from address 0
        send_frame('{8'h04, 8'hA1, 8'hA2}, 2, 1'b0);
        pulse_start();
        chk("ign_start_rdy", 32'(in_ready), 32'd1);
        chk("ign_start_done", 32'(done), 32'd0);
        drain("mid_wq");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
        chk("mid_rst_rdy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        fr = framed('{8'h02, 8'h77, 8'h88});
        send_frame(fr, 2, 1'b0);
        expect_done("reload");
        drain("reload_wq");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
